// File: rtl/queue_calc_ring_pkg.sv
// Shared constants for the queue-machine calculator: command opcodes,
// sticky error codes and the count-width helper.
package queue_calc_pkg;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_MOD  = 3'd6;
    localparam logic [2:0] OP_CLR  = 3'd7;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_UNF  = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_DIVZ = 2'd3;

    // Bits needed to hold an entry count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_calc_ring_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle for WIDTH cycles.
// quotient/remainder are valid in the cycle where done is high.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             busy_r;
    logic [CW-1:0]    step_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // One restoring step: shift the next dividend bit in and subtract if it fits.
    always_comb begin
        trial_s    = {rem_r, quo_r[WIDTH-1]};
        diff_s     = trial_s - {1'b0, dvs_r};
        fits_s     = (trial_s >= {1'b0, dvs_r});
        quo_next_s = {quo_r[WIDTH-2:0], fits_s};
        if (fits_s) begin
            rem_next_s = diff_s[WIDTH-1:0];
        end else begin
            rem_next_s = trial_s[WIDTH-1:0];
        end
    end

    // Iteration state: load on start, step while busy, drop busy after the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            step_r <= {CW{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= {WIDTH{1'b0}};
            dvs_r  <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r <= 1'b1;
            step_r <= {CW{1'b0}};
            rem_r  <= {WIDTH{1'b0}};
            quo_r  <= dividend;
            dvs_r  <= divisor;
        end else if (busy_r) begin
            rem_r  <= rem_next_s;
            quo_r  <= quo_next_s;
            step_r <= step_r + CW'(1);
            if (step_r == LAST_STEP) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = busy_r && (step_r == LAST_STEP);
    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;

endmodule

// File: rtl/queue_calc_ring.sv
// Queue-machine calculator: circular operand buffer with valid/ready command
// handshake, single-cycle ADD/MUL/SUB, iterative DIV/MOD and sticky error code.
module queue_calc_ring
    import queue_calc_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNTW  = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail,
    output logic [CNTW-1:0]  count,
    output logic             empty,
    output logic             full,
    output logic             busy,
    output logic             err,
    output logic [1:0]       err_code,
    input  logic             err_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
    localparam logic [PW-1:0]   PTR_TWO  = PW'(2);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_TWO  = CNTW'(2);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    head_ptr_r;
    logic [PW-1:0]    tail_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             err_r;
    logic [1:0]       err_code_r;
    logic             op_is_mod_r;

    logic             accept_s;
    logic             empty_s;
    logic             full_s;
    logic             has_two_s;
    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             new_err_s;
    logic [1:0]       new_code_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic             do_bin_s;
    logic             do_clr_s;
    logic [WIDTH-1:0] bin_res_s;
    logic             mem_we_s;
    logic [WIDTH-1:0] mem_wdata_s;

    logic             div_start_s;
    logic             div_busy_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] div_rem_s;

    assign accept_s  = in_valid && !div_busy_s;
    assign empty_s   = (count_r == {CNTW{1'b0}});
    assign full_s    = (count_r == CNT_FULL);
    assign has_two_s = (count_r >= CNT_TWO);
    assign a_s       = mem_r[head_ptr_r];
    assign b_s       = mem_r[head_ptr_r + PTR_ONE];

    // Command decode: legality checks and the queue action for this edge.
    always_comb begin
        new_err_s   = 1'b0;
        new_code_s  = ERR_NONE;
        do_push_s   = 1'b0;
        do_pop_s    = 1'b0;
        do_bin_s    = 1'b0;
        do_clr_s    = 1'b0;
        bin_res_s   = {WIDTH{1'b0}};
        div_start_s = 1'b0;
        if (accept_s) begin
            case (op)
                OP_PUSH: begin
                    if (full_s) begin
                        new_err_s  = 1'b1;
                        new_code_s = ERR_OVF;
                    end else begin
                        do_push_s  = 1'b1;
                    end
                end
                OP_POP: begin
                    if (empty_s) begin
                        new_err_s  = 1'b1;
                        new_code_s = ERR_UNF;
                    end else begin
                        do_pop_s   = 1'b1;
                    end
                end
                OP_ADD, OP_MUL, OP_SUB: begin
                    if (!has_two_s) begin
                        new_err_s  = 1'b1;
                        new_code_s = ERR_UNF;
                    end else begin
                        do_bin_s = 1'b1;
                        case (op)
                            OP_ADD:  bin_res_s = b_s + a_s;
                            OP_MUL:  bin_res_s = b_s * a_s;
                            default: bin_res_s = b_s - a_s;
                        endcase
                    end
                end
                OP_DIV, OP_MOD: begin
                    if (!has_two_s) begin
                        new_err_s  = 1'b1;
                        new_code_s = ERR_UNF;
                    end else if (a_s == {WIDTH{1'b0}}) begin
                        new_err_s  = 1'b1;
                        new_code_s = ERR_DIVZ;
                    end else begin
                        div_start_s = 1'b1;
                    end
                end
                OP_CLR: begin
                    do_clr_s = 1'b1;
                end
                default: begin
                    do_clr_s = 1'b0;
                end
            endcase
        end else if (div_done_s) begin
            do_bin_s  = 1'b1;
            bin_res_s = op_is_mod_r ? div_rem_s : div_quo_s;
        end else begin
            do_bin_s  = 1'b0;
        end
    end

    assign mem_we_s    = do_push_s || do_bin_s;
    assign mem_wdata_s = do_push_s ? in_data : bin_res_s;

    // Ring storage; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[tail_ptr_r] <= mem_wdata_s;
        end
    end

    // Pointers and occupancy; binary results pop two then push one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr_r <= {PW{1'b0}};
            tail_ptr_r <= {PW{1'b0}};
            count_r    <= {CNTW{1'b0}};
        end else if (do_clr_s) begin
            head_ptr_r <= {PW{1'b0}};
            tail_ptr_r <= {PW{1'b0}};
            count_r    <= {CNTW{1'b0}};
        end else if (do_push_s) begin
            tail_ptr_r <= tail_ptr_r + PTR_ONE;
            count_r    <= count_r + CNT_ONE;
        end else if (do_pop_s) begin
            head_ptr_r <= head_ptr_r + PTR_ONE;
            count_r    <= count_r - CNT_ONE;
        end else if (do_bin_s) begin
            head_ptr_r <= head_ptr_r + PTR_TWO;
            tail_ptr_r <= tail_ptr_r + PTR_ONE;
            count_r    <= count_r - CNT_ONE;
        end
    end

    // Remember whether the running division should deliver quotient or remainder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_is_mod_r <= 1'b0;
        end else if (div_start_s) begin
            op_is_mod_r <= (op == OP_MOD);
        end
    end

    // Sticky error: first code is kept; a clear on the same edge as a new error yields the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else if (new_err_s && (!err_r || err_clr)) begin
            err_r      <= 1'b1;
            err_code_r <= new_code_s;
        end else if (err_clr && !new_err_s) begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (b_s),
        .divisor  (a_s),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quo_s),
        .remainder(div_rem_s)
    );

    assign head     = empty_s ? {WIDTH{1'b0}} : a_s;
    assign tail     = empty_s ? {WIDTH{1'b0}} : mem_r[tail_ptr_r - PTR_ONE];
    assign count    = count_r;
    assign empty    = empty_s;
    assign full     = full_s;
    assign busy     = div_busy_s;
    assign in_ready = !div_busy_s;
    assign err      = err_r;
    assign err_code = err_code_r;

endmodule

// File: doc/queue_calc_ring.md
Name: queue_calc_ring

Overview:
Parametrised queue-machine calculator. Operands enter at the tail. Binary operations consume the two oldest entries (head, head+1) and append the result at the tail.
Storage is a circular buffer with head/tail pointers instead of a shifting array. Commands use a valid/ready handshake, and DIV/MOD run on a multi-cycle iterative divider.
Error status is sticky and coded. Sits behind the command decoder as the arithmetic engine of the calculator datapath.

Parameters:
WIDTH, 8, data and result width in bits (>=2)
DEPTH, 8, queue capacity in entries (power of two, >=2)
CNTW, $clog2(DEPTH+1), width of count output (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  command present
in_ready  out  1  engine can accept a command (= !busy)
op  in  3  0 PUSH, 1 POP, 2 ADD, 3 MUL, 4 SUB, 5 DIV, 6 MOD, 7 CLR
in_data  in  WIDTH  operand for PUSH; ignored otherwise
head  out  WIDTH  oldest entry; 0 when empty
tail  out  WIDTH  newest entry; 0 when empty
count  out  CNTW  number of valid entries
empty  out  1  count==0
full  out  1  count==DEPTH
busy  out  1  divider running
err  out  1  sticky error flag
err_code  out  2  0 none, 1 underflow, 2 overflow, 3 divide-by-zero
err_clr  in  1  synchronous clear of err/err_code

Behaviour:
- Reset (async): pointers=0, count=0, busy=0, err=0, err_code=0, divider idle. Outputs: head=tail=0, empty=1, full=0, in_ready=1. Storage contents are don't-care. Reset during a division aborts it.
- Accept: a command is taken on a rising edge with in_valid && in_ready. Without acceptance, nothing changes except err_clr.
- Let A=entry[head], B=entry[head+1]. Results are truncated to WIDTH bits, unsigned.
- ADD: A+B. MUL: low WIDTH bits of A*B. SUB: B-A, mod 2^WIDTH. DIV: B/A. MOD: B%A.
- PUSH: write in_data at tail, tail_ptr+1, count+1. Visible on head/tail/count after the accepting edge.
- POP: head_ptr+1, count-1.
- CLR: pointers=0, count=0; err is untouched.
- ADD/MUL/SUB are single-cycle. On the accepting edge: head_ptr+2, result written at tail_ptr, tail_ptr+1, net count-1. Legal when full, because the pop happens before the push.
- DIV/MOD:
  - On accept, latch A, B and the op, and set busy.
  - The divider runs exactly WIDTH cycles (restoring, 1 quotient bit per cycle).
  - On the WIDTH-th edge after acceptance, the queue update occurs (as for ADD) and busy falls. in_ready returns high in the same cycle.
  - The queue is frozen while busy; head/tail/count hold their pre-op values.
- Pointer wrap: pointers are modulo DEPTH, via natural overflow of $clog2(DEPTH)-bit counters.
- Errors: on an illegal command the queue is unchanged, the command is consumed (handshake completes), and err is set.
  - PUSH when full -> code 2.
  - POP when empty, or binary op with count<2 -> code 1.
  - DIV/MOD with A==0 -> code 3, detected at acceptance; no busy cycle.
  - err_code keeps the first error until cleared. Later errors do not overwrite it.
  - err_clr clears err/err_code on the next edge. If a new error occurs on the same edge, the new error wins.
  - Commands continue to execute normally while err=1.
- Unknown/X op is not required to be handled.

Decomposition:
- Package queue_calc_pkg holds:
  - the op encoding constants (OP_PUSH..OP_CLR);
  - the error code constants (ERR_NONE, ERR_UNF, ERR_OVF, ERR_DIVZ);
  - a helper function for the count width.
- One sub-module, seq_divider (parameter WIDTH):
  - inputs: start, dividend, divisor;
  - outputs: busy, done, quotient, remainder.
- The top level owns the ring buffer, pointers, handshake and error logic.

Test Plan:
1. WIDTH=8, DEPTH=4. PUSH 10, PUSH 3, SUB -> count=1, head=tail=0xF9, err=0.
2. PUSH 7, PUSH 200, DIV -> in_ready=0 for 8 cycles, then count=1, tail=28. Repeat with MOD -> tail=4.
3. PUSH 16 x4 -> full=1. 5th PUSH -> err=1, code 2, count=4. MUL -> count=3, tail=0 (256 truncated). Then 6 alternating POP/PUSH to wrap pointers -> head/tail track the pushed values exactly.
4. POP on empty -> err=1, code 1. Then PUSH 5, PUSH 0 -> code remains 1. err_clr -> err=0, code 0.
5. PUSH 0, PUSH 5, DIV -> err=1, code 3, busy never asserted, count=2, head=0, tail=5.
6. PUSH 9, PUSH 99, DIV, assert reset on the 3rd busy cycle -> count=0, busy=0, in_ready=1, empty=1 immediately; the next PUSH works normally.
